// File: rtl/bram_pkg.sv
// Shared types and helpers for the dual-port RAM: write-collision mode,
// sweep FSM states and the per-byte merge used by both ports.
package bram_pkg;

  typedef enum logic {READ_FIRST, WRITE_FIRST} bram_mode_t;

  typedef enum logic {IDLE, SWEEP} bram_state_t;

  localparam int BYTE_W = 8;

  // Select the new byte where its enable is set, otherwise keep the old one.
  function automatic logic [BYTE_W-1:0] byte_merge(
    input logic [BYTE_W-1:0] old_byte,
    input logic [BYTE_W-1:0] new_byte,
    input logic              be
  );
    return be ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/bram_read_pipe.sv
// Fixed-depth valid/data delay line for one RAM port; the output word is held
// between valid strobes and the whole line clears on asynchronous reset.
module bram_read_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [LATENCY-1:0]    v_q;
  logic [LATENCY-1:0]    v_in;
  logic [DATA_WIDTH-1:0] d_q  [LATENCY];
  logic [DATA_WIDTH-1:0] d_in [LATENCY];

  always_comb begin
    v_in[0] = in_valid;
    d_in[0] = in_data;
    for (int i = 1; i < LATENCY; i++) begin
      v_in[i] = v_q[i-1];
      d_in[i] = d_q[i-1];
    end
  end

  // Only the last stage is gated so data_out keeps the previous word when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= '0;
      for (int i = 0; i < LATENCY; i++) d_q[i] <= '0;
    end else begin
      v_q <= v_in;
      for (int i = 0; i < LATENCY; i++) begin
        if (i == LATENCY - 1) begin
          if (v_in[i]) d_q[i] <= d_in[i];
        end else begin
          d_q[i] <= d_in[i];
        end
      end
    end
  end

  assign out_valid = v_q[LATENCY-1];
  assign out_data  = d_q[LATENCY-1];

endmodule

// File: rtl/dual_port_ram.sv
// True dual-port RAM with byte enables, defined cross-port collision merging,
// configurable read latency and a zero-fill sweep engine.
module dual_port_ram
  import bram_pkg::*;
#(
  parameter int         DATA_WIDTH     = 32,
  parameter int         ADDR_WIDTH     = 10,
  parameter int         READ_LATENCY   = 1,
  parameter bram_mode_t WRITE_MODE     = WRITE_FIRST,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  output logic                    busy,
  output bram_state_t             state_dbg,
  input  logic                    en_1,
  input  logic                    en_2,
  input  logic [DATA_WIDTH/8-1:0] write_en_1,
  input  logic [DATA_WIDTH/8-1:0] write_en_2,
  input  logic [ADDR_WIDTH-1:0]   addr_1,
  input  logic [ADDR_WIDTH-1:0]   addr_2,
  input  logic [DATA_WIDTH-1:0]   data_in_1,
  input  logic [DATA_WIDTH-1:0]   data_in_2,
  output logic [DATA_WIDTH-1:0]   data_out_1,
  output logic [DATA_WIDTH-1:0]   data_out_2,
  output logic                    rvalid_1,
  output logic                    rvalid_2
);

  localparam int NB    = DATA_WIDTH / BYTE_W;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  bram_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  logic                  acc_1, acc_2, same_addr;
  logic [NB-1:0]         wbe_1, wbe_2;
  logic [DATA_WIDTH-1:0] old_1, old_2, fin_1, fin_2, rdata_1, rdata_2;

  // Sweep FSM: one word zeroed per cycle, clear ignored while sweeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR_ON_RESET ? SWEEP : IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == SWEEP);
  assign state_dbg = state_q;

  assign acc_1     = en_1 && !busy;
  assign acc_2     = en_2 && !busy;
  assign wbe_1     = acc_1 ? write_en_1 : '0;
  assign wbe_2     = acc_2 ? write_en_2 : '0;
  assign same_addr = (addr_1 == addr_2);
  assign old_1     = mem[addr_1];
  assign old_2     = mem[addr_2];

  // fin_x is the word left at addr_x after this edge; on a shared address
  // both ports compute the same word, with port 1 winning contested bytes.
  always_comb begin
    fin_1 = old_1;
    fin_2 = old_2;
    for (int b = 0; b < NB; b++) begin
      fin_1[b*BYTE_W +: BYTE_W] = byte_merge(
        byte_merge(old_1[b*BYTE_W +: BYTE_W], data_in_2[b*BYTE_W +: BYTE_W],
                   same_addr && wbe_2[b]),
        data_in_1[b*BYTE_W +: BYTE_W], wbe_1[b]);
      fin_2[b*BYTE_W +: BYTE_W] = byte_merge(
        byte_merge(old_2[b*BYTE_W +: BYTE_W], data_in_2[b*BYTE_W +: BYTE_W], wbe_2[b]),
        data_in_1[b*BYTE_W +: BYTE_W], same_addr && wbe_1[b]);
    end
  end

  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt_q] <= '0;
    end else begin
      if (|wbe_2) mem[addr_2] <= fin_2;
      if (|wbe_1) mem[addr_1] <= fin_1;
    end
  end

  assign rdata_1 = (WRITE_MODE == WRITE_FIRST) ? fin_1 : old_1;
  assign rdata_2 = (WRITE_MODE == WRITE_FIRST) ? fin_2 : old_2;

  bram_read_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (READ_LATENCY)
  ) u_pipe_1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (acc_1),
    .in_data   (rdata_1),
    .out_valid (rvalid_1),
    .out_data  (data_out_1)
  );

  bram_read_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (READ_LATENCY)
  ) u_pipe_2 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (acc_2),
    .in_data   (rdata_2),
    .out_valid (rvalid_2),
    .out_data  (data_out_2)
  );

endmodule

// File: tb/tb_dual_port_ram.sv
// Bench for dual_port_ram: a WRITE_FIRST/latency-2 and a READ_FIRST/latency-3
// instance share all inputs and are checked against one behavioural memory model.
module tb_dual_port_ram;
  import bram_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        en_1 = 1'b0, en_2 = 1'b0;
  logic [3:0]  write_en_1 = '0, write_en_2 = '0;
  logic [3:0]  addr_1 = '0, addr_2 = '0;
  logic [31:0] data_in_1 = '0, data_in_2 = '0;

  logic        busy_a, busy_b, rvalid_1_a, rvalid_2_a, rvalid_1_b, rvalid_2_b;
  logic [31:0] data_out_1_a, data_out_2_a, data_out_1_b, data_out_2_b;
  bram_state_t state_dbg_a, state_dbg_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dual_port_ram #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2),
    .WRITE_MODE(WRITE_FIRST), .CLEAR_ON_RESET(1'b1)
  ) dut_a (
    .clk(clk), .reset(reset), .clear(clear), .busy(busy_a), .state_dbg(state_dbg_a),
    .en_1(en_1), .en_2(en_2), .write_en_1(write_en_1), .write_en_2(write_en_2),
    .addr_1(addr_1), .addr_2(addr_2), .data_in_1(data_in_1), .data_in_2(data_in_2),
    .data_out_1(data_out_1_a), .data_out_2(data_out_2_a),
    .rvalid_1(rvalid_1_a), .rvalid_2(rvalid_2_a)
  );

  dual_port_ram #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(3),
    .WRITE_MODE(READ_FIRST), .CLEAR_ON_RESET(1'b1)
  ) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .busy(busy_b), .state_dbg(state_dbg_b),
    .en_1(en_1), .en_2(en_2), .write_en_1(write_en_1), .write_en_2(write_en_2),
    .addr_1(addr_1), .addr_2(addr_2), .data_in_1(data_in_1), .data_in_2(data_in_2),
    .data_out_1(data_out_1_b), .data_out_2(data_out_2_b),
    .rvalid_1(rvalid_1_b), .rvalid_2(rvalid_2_b)
  );

  // ---------------- model and scoreboard ----------------
  // Channels: 0 = a port 1, 1 = a port 2, 2 = b port 1, 3 = b port 2.
  logic [31:0] exp_q [4][$];
  int          due_q [4][$];
  logic [31:0] last_d [4];
  logic [31:0] mmem [16];
  bit          mstate = 1'b1;
  int          mcnt = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;

  task automatic model_reset();
    for (int ch = 0; ch < 4; ch++) begin
      exp_q[ch].delete();
      due_q[ch].delete();
      last_d[ch] = '0;
    end
    mstate = 1'b1;
    mcnt   = 0;
  endtask

  always @(posedge reset) model_reset();

  always @(posedge clk) begin
    logic [31:0] old1, old2;
    cyc = cyc + 1;
    if (reset) begin
      model_reset();
    end else if (mstate) begin
      mmem[mcnt] = '0;
      if (mcnt == 15) mstate = 1'b0;
      mcnt = (mcnt + 1) % 16;
    end else begin
      old1 = mmem[addr_1];
      old2 = mmem[addr_2];
      for (int b = 0; b < 4; b++)
        if (en_2 && write_en_2[b]) mmem[addr_2][b*8 +: 8] = data_in_2[b*8 +: 8];
      for (int b = 0; b < 4; b++)
        if (en_1 && write_en_1[b]) mmem[addr_1][b*8 +: 8] = data_in_1[b*8 +: 8];
      if (en_1) begin
        exp_q[0].push_back(mmem[addr_1]); due_q[0].push_back(cyc + 1);
        exp_q[2].push_back(old1);         due_q[2].push_back(cyc + 2);
      end
      if (en_2) begin
        exp_q[1].push_back(mmem[addr_2]); due_q[1].push_back(cyc + 1);
        exp_q[3].push_back(old2);         due_q[3].push_back(cyc + 2);
      end
      if (clear) begin
        mstate = 1'b1;
        mcnt   = 0;
      end
    end
  end

  logic        ov [4];
  logic [31:0] od [4];
  logic        mon_exp_v;
  logic [31:0] mon_e;

  always @(negedge clk) begin
    if (mon_en) begin
      ov[0] = rvalid_1_a; ov[1] = rvalid_2_a; ov[2] = rvalid_1_b; ov[3] = rvalid_2_b;
      od[0] = data_out_1_a; od[1] = data_out_2_a; od[2] = data_out_1_b; od[3] = data_out_2_b;
      for (int ch = 0; ch < 4; ch++) begin
        mon_exp_v = (due_q[ch].size() > 0) && (due_q[ch][0] == cyc);
        n_cmp++;
        if (ov[ch] !== mon_exp_v) begin
          n_err++;
          $display("FAIL rvalid ch%0d cycle %0d: got %b expected %b", ch, cyc, ov[ch], mon_exp_v);
        end
        if (mon_exp_v) begin
          mon_e = exp_q[ch].pop_front();
          void'(due_q[ch].pop_front());
          n_cmp++;
          if (od[ch] !== mon_e) begin
            n_err++;
            $display("FAIL rdata ch%0d cycle %0d: got %h expected %h", ch, cyc, od[ch], mon_e);
          end
          last_d[ch] = mon_e;
        end else begin
          n_cmp++;
          if (od[ch] !== last_d[ch]) begin
            n_err++;
            $display("FAIL hold ch%0d cycle %0d: got %h expected %h", ch, cyc, od[ch], last_d[ch]);
          end
        end
      end
      n_cmp++;
      if (busy_a !== mstate || busy_b !== mstate) begin
        n_err++;
        $display("FAIL busy cycle %0d: got a=%b b=%b expected %b", cyc, busy_a, busy_b, mstate);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle_req(
    input logic e1, input logic [3:0] w1, input logic [3:0] a1, input logic [31:0] d1,
    input logic e2, input logic [3:0] w2, input logic [3:0] a2, input logic [31:0] d2,
    input logic clr
  );
    en_1 = e1; write_en_1 = w1; addr_1 = a1; data_in_1 = d1;
    en_2 = e2; write_en_2 = w2; addr_2 = a2; data_in_2 = d2;
    clear = clr;
    @(posedge clk); #1;
    en_1 = 1'b0; en_2 = 1'b0; write_en_1 = '0; write_en_2 = '0; clear = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy_a === 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    repeat (5) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int n;
    @(posedge clk); #1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (busy_a !== 1'b1 || state_dbg_a !== SWEEP) begin
      n_err++;
      $display("FAIL reset_busy: got busy=%b state=%0d expected 1/SWEEP", busy_a, state_dbg_a);
    end
    n_cmp++;
    if ({rvalid_1_a, rvalid_2_a, rvalid_1_b, rvalid_2_b} !== 4'b0000 ||
        (data_out_1_a | data_out_2_a | data_out_1_b | data_out_2_b) !== 32'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got rvalids %b%b%b%b expected 0000 and zero data",
               rvalid_1_a, rvalid_2_a, rvalid_1_b, rvalid_2_b);
    end
    reset = 1'b0;
    count_busy(n);
    n_cmp++;
    if (n != 16) begin
      n_err++;
      $display("FAIL reset_sweep_len: got %0d busy cycles expected 16", n);
    end
  endtask

  task automatic test_read_all();
    for (int i = 0; i < 16; i++)
      cycle_req(1'b1, 4'h0, 4'(i), 32'($urandom()), 1'b1, 4'h0, 4'(15 - i), 32'($urandom()), 1'b0);
    drain();
  endtask

  task automatic test_byte_merge();
    cycle_req(1'b1, 4'hF, 4'd3, 32'h11223344, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
    cycle_req(1'b1, 4'b0101, 4'd3, 32'hAABBCCDD, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
    @(posedge clk); #1;
    n_cmp++;
    if (rvalid_1_a !== 1'b1 || data_out_1_a !== 32'h11BB33DD) begin
      n_err++;
      $display("FAIL merge_write_first: got %b/%h expected 1/11bb33dd", rvalid_1_a, data_out_1_a);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (rvalid_1_b !== 1'b1 || data_out_1_b !== 32'h11223344) begin
      n_err++;
      $display("FAIL merge_read_first: got %b/%h expected 1/11223344", rvalid_1_b, data_out_1_b);
    end
    drain();
  endtask

  task automatic test_collision();
    cycle_req(1'b1, 4'hF, 4'd5, 32'h12AB0000, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
    cycle_req(1'b1, 4'b0011, 4'd5, 32'hFFFFFFFF, 1'b1, 4'b0110, 4'd5, 32'h12345678, 1'b0);
    cycle_req(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'h0, 4'd5, 32'h0, 1'b0);
    n_cmp++;
    if (data_out_1_a !== 32'h1234FFFF || data_out_2_a !== 32'h1234FFFF) begin
      n_err++;
      $display("FAIL collide_return: got %h/%h expected 1234ffff", data_out_1_a, data_out_2_a);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (data_out_2_a !== 32'h1234FFFF) begin
      n_err++;
      $display("FAIL collide_stored: got %h expected 1234ffff", data_out_2_a);
    end
    n_cmp++;
    if (data_out_1_b !== 32'h12AB0000) begin
      n_err++;
      $display("FAIL collide_read_first: got %h expected 12ab0000", data_out_1_b);
    end
    drain();
  endtask

  task automatic test_read_first();
    cycle_req(1'b1, 4'hF, 4'd7, 32'hCAFEBABE, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
    cycle_req(1'b1, 4'hF, 4'd7, 32'h0, 1'b1, 4'h0, 4'd7, 32'h0, 1'b0);
    cycle_req(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'h0, 4'd7, 32'h0, 1'b0);
    n_cmp++;
    if (data_out_2_a !== 32'h0) begin
      n_err++;
      $display("FAIL cross_write_first: got %h expected 00000000", data_out_2_a);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (data_out_2_b !== 32'hCAFEBABE) begin
      n_err++;
      $display("FAIL cross_read_first: got %h expected cafebabe", data_out_2_b);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (data_out_2_b !== 32'h0) begin
      n_err++;
      $display("FAIL cross_next_read: got %h expected 00000000", data_out_2_b);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    repeat (150)
      cycle_req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                32'($urandom()),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                32'($urandom()), 1'b0);
    drain();
  endtask

  task automatic test_clear();
    int n;
    cycle_req(1'b1, 4'h0, 4'd2, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
    cycle_req(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b1);
    @(posedge clk); #1;
    n_cmp++;
    if (rvalid_1_b !== 1'b1 || busy_b !== 1'b1) begin
      n_err++;
      $display("FAIL clear_drain: got rvalid=%b busy=%b expected 1/1", rvalid_1_b, busy_b);
    end
    repeat (5)
      cycle_req(1'b1, 4'hF, 4'd0, 32'hDEAD0001, 1'b1, 4'h0, 4'd1, 32'h0, 1'b1);
    count_busy(n);
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL clear_timeout: got busy=%b after %0d cycles expected 0", busy_a, n);
    end
    cycle_req(1'b1, 4'h0, 4'd0, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
    @(posedge clk); #1;
    n_cmp++;
    if (rvalid_1_a !== 1'b1 || data_out_1_a !== 32'h0) begin
      n_err++;
      $display("FAIL clear_no_write: got %b/%h expected 1/00000000", rvalid_1_a, data_out_1_a);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int n;
    cycle_req(1'b1, 4'h0, 4'd1, 32'h0, 1'b1, 4'h0, 4'd2, 32'h0, 1'b0);
    cycle_req(1'b1, 4'h0, 4'd3, 32'h0, 1'b1, 4'h0, 4'd4, 32'h0, 1'b0);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({rvalid_1_a, rvalid_2_a, rvalid_1_b, rvalid_2_b} !== 4'b0000 ||
        (data_out_1_a | data_out_2_a | data_out_1_b | data_out_2_b) !== 32'h0) begin
      n_err++;
      $display("FAIL midpipe_flush: got rvalids %b%b%b%b expected 0000 and zero data",
               rvalid_1_a, rvalid_2_a, rvalid_1_b, rvalid_2_b);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    count_busy(n);
    n_cmp++;
    if (n != 16) begin
      n_err++;
      $display("FAIL midpipe_sweep_len: got %0d expected 16", n);
    end
    cycle_req(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    n_cmp++;
    if (state_dbg_a !== SWEEP) begin
      n_err++;
      $display("FAIL midsweep_state: got %0d expected SWEEP", state_dbg_a);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    count_busy(n);
    n_cmp++;
    if (n != 16) begin
      n_err++;
      $display("FAIL midsweep_restart: got %0d busy cycles expected 16", n);
    end
    cycle_req(1'b1, 4'h0, 4'd9, 32'h0, 1'b1, 4'h0, 4'd15, 32'h0, 1'b0);
    drain();
  endtask

  initial begin
    test_reset();
    test_read_all();
    test_byte_merge();
    test_collision();
    test_read_first();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    n_cmp++;
    if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() != 0) begin
      n_err++;
      $display("FAIL leftover: got %0d undelivered reads expected 0",
               exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
